// File: rtl/ddr_burst_arbiter.sv
`timescale 1ns/1ps
// ddr_burst_arbiter
// Arbitrates write bursts (rx packet FIFO -> DDR ring) and read bursts
// (DDR ring -> playback FIFO) onto a single DDR command port. The DDR
// region is managed as a ring of 2^DEPTH_LOG2 bursts. Playback starts
// once START_THRESH bursts are stored. After rxEnd, the ring is drained
// until it is empty; then playDone pulses and the ring restarts at slot 0.
//
// Ports
//   clk        sole clock, rising edge
//   reset      asynchronous active-high reset
//   wrReq      rx FIFO holds at least one full burst
//   wrGrant    one-cycle pulse when a write command is accepted
//   rdReq      playback FIFO has room for one burst
//   rdGrant    one-cycle pulse when a read command is accepted
//   rxEnd      one-cycle pulse marking end of reception (starts drain)
//   cmd_valid  DDR command valid
//   cmd_ready  DDR controller accepts command
//   cmd_write  1 = write burst, 0 = read burst
//   cmd_addr   burst start address
//   occupancy  bursts stored and not yet read
//   full       ring holds 2^DEPTH_LOG2 bursts
//   empty      ring holds no bursts
//   playDone   one-cycle pulse when drain completes
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | no command outstanding; requests sampled, drain completion
// ISSUE_WR | write command presented, waiting for cmd_ready
// ISSUE_RD | read command presented, waiting for cmd_ready

module ddr_burst_arbiter #(
    parameter int ADDR_W       = 28,
    parameter int DEPTH_LOG2   = 12,
    parameter int BURST_STEP   = 8,
    parameter int BASE_ADDR    = 0,
    parameter int START_THRESH = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wrReq,
    output logic                  wrGrant,
    input  logic                  rdReq,
    output logic                  rdGrant,
    input  logic                  rxEnd,
    output logic                  cmd_valid,
    input  logic                  cmd_ready,
    output logic                  cmd_write,
    output logic [ADDR_W-1:0]     cmd_addr,
    output logic [DEPTH_LOG2:0]   occupancy,
    output logic                  full,
    output logic                  empty,
    output logic                  playDone
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ISSUE_WR = 2'd1,
        ISSUE_RD = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0]     BASE_A   = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0]     STEP_A   = ADDR_W'(BURST_STEP);
    localparam logic [DEPTH_LOG2:0]   OCC_FULL = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [DEPTH_LOG2:0]   OCC_ONE  = (DEPTH_LOG2+1)'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);
    // Threshold compared in 32 bits so a threshold above the ring depth
    // simply never starts playback instead of wrapping to a small value.
    localparam logic [31:0]           THRESH_U = 32'(START_THRESH);

    state_t                  state_q;
    state_t                  state_d;
    logic [DEPTH_LOG2-1:0]   wr_ptr_q;
    logic [DEPTH_LOG2-1:0]   rd_ptr_q;
    logic [DEPTH_LOG2:0]     occ_q;
    logic [DEPTH_LOG2:0]     occ_d;
    logic                    drain_q;
    logic                    playing_q;
    logic                    last_wr_q;
    logic                    cmd_write_q;
    logic [ADDR_W-1:0]       cmd_addr_q;
    logic                    wr_elig;
    logic                    rd_elig;

    function automatic logic [ADDR_W-1:0] burst_addr(input logic [DEPTH_LOG2-1:0] ptr);
        return BASE_A + ADDR_W'(ptr) * STEP_A;
    endfunction

    assign empty     = (occ_q == '0);
    assign full      = (occ_q == OCC_FULL);
    assign occupancy = occ_q;
    assign cmd_write = cmd_write_q;
    assign cmd_addr  = cmd_addr_q;

    assign wr_elig = wrReq && !full;
    assign rd_elig = rdReq && !empty && (playing_q || drain_q);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cmd_valid = 1'b0;
        wrGrant   = 1'b0;
        rdGrant   = 1'b0;
        playDone  = 1'b0;
        case (state_q)
            IDLE: begin
                // Drain completion takes the whole cycle: the pointers are
                // rewound now, so no command may pick up a stale address.
                if (drain_q && empty) begin
                    playDone = 1'b1;
                end else if (wr_elig && rd_elig) begin
                    state_d = last_wr_q ? ISSUE_RD : ISSUE_WR;
                end else if (wr_elig) begin
                    state_d = ISSUE_WR;
                end else if (rd_elig) begin
                    state_d = ISSUE_RD;
                end
            end
            ISSUE_WR: begin
                cmd_valid = 1'b1;
                if (cmd_ready) begin
                    wrGrant = 1'b1;
                    state_d = IDLE;
                end
            end
            ISSUE_RD: begin
                cmd_valid = 1'b1;
                if (cmd_ready) begin
                    rdGrant = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        occ_d = occ_q;
        if (wrGrant) begin
            occ_d = occ_q + OCC_ONE;
        end else if (rdGrant) begin
            occ_d = occ_q - OCC_ONE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            occ_q       <= '0;
            drain_q     <= 1'b0;
            playing_q   <= 1'b0;
            last_wr_q   <= 1'b0;
            cmd_write_q <= 1'b0;
            cmd_addr_q  <= BASE_A;
        end else begin
            occ_q <= occ_d;

            // Command fields are captured once on entry to ISSUE_* and then
            // held until the handshake, independent of later pointer moves.
            if (state_q == IDLE && state_d == ISSUE_WR) begin
                cmd_write_q <= 1'b1;
                cmd_addr_q  <= burst_addr(wr_ptr_q);
            end else if (state_q == IDLE && state_d == ISSUE_RD) begin
                cmd_write_q <= 1'b0;
                cmd_addr_q  <= burst_addr(rd_ptr_q);
            end

            if (wrGrant) begin
                wr_ptr_q  <= wr_ptr_q + PTR_ONE;
                last_wr_q <= 1'b1;
            end
            if (rdGrant) begin
                rd_ptr_q  <= rd_ptr_q + PTR_ONE;
                last_wr_q <= 1'b0;
            end

            if (playDone) begin
                wr_ptr_q  <= '0;
                rd_ptr_q  <= '0;
                drain_q   <= 1'b0;
                playing_q <= 1'b0;
            end else begin
                if (rxEnd) begin
                    drain_q <= 1'b1;
                end
                // Using the post-update occupancy lets playback become
                // eligible in the same IDLE cycle the threshold is reached.
                if (32'(occ_d) >= THRESH_U) begin
                    playing_q <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_ddr_burst_arbiter.sv
`timescale 1ns/1ps
module tb_ddr_burst_arbiter;

    localparam int AW = 28;

    logic clk = 1'b0;
    logic reset;
    logic wr_req[2];
    logic rd_req[2];
    logic rx_end[2];
    logic cmd_ready[2];
    logic wr_grant[2];
    logic rd_grant[2];
    logic cmd_valid[2];
    logic cmd_write[2];
    logic play_done[2];
    logic full[2];
    logic empty[2];
    logic [AW-1:0] cmd_addr[2];
    logic [12:0] occ0;
    logic [2:0]  occ1;

    always #5 clk = ~clk;

    ddr_burst_arbiter u_dut (
        .clk(clk), .reset(reset),
        .wrReq(wr_req[0]), .wrGrant(wr_grant[0]),
        .rdReq(rd_req[0]), .rdGrant(rd_grant[0]),
        .rxEnd(rx_end[0]),
        .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]),
        .cmd_write(cmd_write[0]), .cmd_addr(cmd_addr[0]),
        .occupancy(occ0), .full(full[0]), .empty(empty[0]),
        .playDone(play_done[0])
    );

    ddr_burst_arbiter #(.DEPTH_LOG2(2), .BASE_ADDR('h100)) u_small (
        .clk(clk), .reset(reset),
        .wrReq(wr_req[1]), .wrGrant(wr_grant[1]),
        .rdReq(rd_req[1]), .rdGrant(rd_grant[1]),
        .rxEnd(rx_end[1]),
        .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]),
        .cmd_write(cmd_write[1]), .cmd_addr(cmd_addr[1]),
        .occupancy(occ1), .full(full[1]), .empty(empty[1]),
        .playDone(play_done[1])
    );

    int n_checks = 0;
    int n_errors = 0;

    // reference model of the ring, per instance
    int m_wr[2];
    int m_rd[2];
    int m_occ[2];
    int depth[2] = '{4096, 4};
    int base[2]  = '{0, 'h100};

    typedef struct {
        logic          w;
        logic [AW-1:0] addr;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        logic w;
        logic r;
        logic exp_w;
        int   delay;
        int   exp_occ;
    } vec_t;
    vec_t tbl[9];

    function automatic logic [AW-1:0] addr_of(input int u, input int p);
        return AW'(base[u] + p * 8);
    endfunction

    function automatic int occ_of(input int u);
        return (u == 0) ? int'(occ0) : int'(occ1);
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic model_rewind(input int u);
        m_wr[u]  = 0;
        m_rd[u]  = 0;
    endtask

    task automatic pulse_rx(input int u);
        rx_end[u] = 1'b1;
        @(negedge clk);
        rx_end[u] = 1'b0;
    endtask

    task automatic no_cmd(input int u, input logic w, input logic r, input int n, input string name);
        logic seen;
        seen = 1'b0;
        wr_req[u] = w;
        rd_req[u] = r;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (cmd_valid[u]) seen = 1'b1;
        end
        wr_req[u] = 1'b0;
        rd_req[u] = 1'b0;
        chk(name, seen, 0);
        @(negedge clk);
    endtask

    // Issue one command; requests drop as soon as the command is presented.
    task automatic cmd(input int u, input logic w, input logic r, input logic exp_w, input int delay);
        exp_t e;
        logic [AW-1:0] held;
        int n;
        e.w    = exp_w;
        e.addr = exp_w ? addr_of(u, m_wr[u]) : addr_of(u, m_rd[u]);
        sb.push_back(e);
        wr_req[u]    = w;
        rd_req[u]    = r;
        cmd_ready[u] = (delay == 0);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!cmd_valid[u] && n < 20);
        wr_req[u] = 1'b0;
        rd_req[u] = 1'b0;
        if (!cmd_valid[u]) begin
            chk("cmd_timeout", 0, 1);
            void'(sb.pop_front());
            cmd_ready[u] = 1'b1;
            return;
        end
        held = cmd_addr[u];
        for (int i = 0; i < delay; i++) begin
            chk("stall_hold", (cmd_valid[u] && cmd_addr[u] == held && !wr_grant[u] && !rd_grant[u]), 1);
            @(negedge clk);
        end
        cmd_ready[u] = 1'b1;
        #1;
        e = sb.pop_front();
        chk("cmd_write", cmd_write[u], e.w);
        chk("cmd_addr", cmd_addr[u], e.addr);
        chk("grant", {wr_grant[u], rd_grant[u]}, {e.w, !e.w});
        @(negedge clk);
        chk("post_valid", cmd_valid[u], 0);
        chk("post_grant", wr_grant[u] | rd_grant[u], 0);
        if (exp_w) begin
            m_wr[u] = (m_wr[u] + 1) % depth[u];
            m_occ[u]++;
        end else begin
            m_rd[u] = (m_rd[u] + 1) % depth[u];
            m_occ[u]--;
        end
        chk("occupancy", occ_of(u), m_occ[u]);
    endtask

    task automatic check_done(input int u);
        chk("play_done_pulse", play_done[u], 1);
        @(negedge clk);
        chk("play_done_once", play_done[u], 0);
        chk("empty_after_done", empty[u], 1);
        model_rewind(u);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        logic seen;

        // starting at occupancy 16 with last grant = write
        tbl[0] = '{1'b1, 1'b1, 1'b0, 0, 15};
        tbl[1] = '{1'b1, 1'b1, 1'b1, 0, 16};
        tbl[2] = '{1'b1, 1'b1, 1'b0, 2, 15};
        tbl[3] = '{1'b1, 1'b1, 1'b1, 5, 16};
        tbl[4] = '{1'b0, 1'b1, 1'b0, 0, 15};
        tbl[5] = '{1'b0, 1'b1, 1'b0, 0, 14};
        tbl[6] = '{1'b1, 1'b0, 1'b1, 0, 15};
        tbl[7] = '{1'b1, 1'b1, 1'b0, 0, 14};
        tbl[8] = '{1'b1, 1'b1, 1'b1, 0, 15};

        for (int u = 0; u < 2; u++) begin
            wr_req[u] = 1'b0; rd_req[u] = 1'b0; rx_end[u] = 1'b0; cmd_ready[u] = 1'b1;
            m_wr[u] = 0; m_rd[u] = 0; m_occ[u] = 0;
        end
        reset = 1'b1;
        repeat (3) @(negedge clk);

        chk("rst_valid", cmd_valid[0], 0);
        chk("rst_write", cmd_write[0], 0);
        chk("rst_addr", cmd_addr[0], 0);
        chk("rst_addr_small", cmd_addr[1], 'h100);
        chk("rst_occ", occ0, 0);
        chk("rst_empty", empty[0], 1);
        chk("rst_full", full[0], 0);
        chk("rst_grants", wr_grant[0] | rd_grant[0] | play_done[0], 0);
        reset = 1'b0;
        @(negedge clk);

        // short fill below threshold, then drain
        no_cmd(0, 1'b0, 1'b1, 4, "rd_when_empty");
        for (int i = 0; i < 3; i++) cmd(0, 1'b1, 1'b0, 1'b1, 0);
        no_cmd(0, 1'b0, 1'b1, 4, "rd_before_play");
        pulse_rx(0);
        pulse_rx(0);
        for (int i = 0; i < 3; i++) cmd(0, 1'b0, 1'b1, 1'b0, 0);
        chk("drain_addr_last", cmd_addr[0], 16);
        check_done(0);

        // fill to threshold
        for (int i = 0; i < 15; i++) cmd(0, 1'b1, 1'b0, 1'b1, 0);
        no_cmd(0, 1'b0, 1'b1, 4, "rd_below_thresh");
        cmd(0, 1'b1, 1'b0, 1'b1, 0);
        chk("thresh_addr", cmd_addr[0], 120);

        // round-robin and stall vectors
        for (int i = 0; i < 9; i++) begin
            cmd(0, tbl[i].w, tbl[i].r, tbl[i].exp_w, tbl[i].delay);
            chk($sformatf("tbl_occ_%0d", i), occ_of(0), tbl[i].exp_occ);
        end

        // drain with one write accepted while draining
        pulse_rx(0);
        cmd(0, 1'b1, 1'b0, 1'b1, 0);
        for (int k = 0; k < 40 && m_occ[0] > 0; k++) cmd(0, 1'b0, 1'b1, 1'b0, 0);
        check_done(0);
        cmd(0, 1'b1, 1'b0, 1'b1, 0);
        chk("restart_addr", cmd_addr[0], 0);
        no_cmd(0, 1'b0, 1'b1, 4, "playing_cleared");

        // small ring: full, wrap
        for (int i = 0; i < 4; i++) cmd(1, 1'b1, 1'b0, 1'b1, 0);
        chk("small_full", full[1], 1);
        no_cmd(1, 1'b1, 1'b0, 5, "wr_when_full");
        pulse_rx(1);
        cmd(1, 1'b0, 1'b1, 1'b0, 0);
        chk("small_not_full", full[1], 0);
        cmd(1, 1'b1, 1'b0, 1'b1, 0);
        chk("small_wrap_addr", cmd_addr[1], 'h100);
        chk("small_full_again", full[1], 1);
        for (int k = 0; k < 10 && m_occ[1] > 0; k++) cmd(1, 1'b0, 1'b1, 1'b0, 0);
        check_done(1);

        // reset while a command is pending
        wr_req[0] = 1'b1;
        cmd_ready[0] = 1'b0;
        seen = 1'b0;
        n = 0;
        while (!seen && n < 10) begin
            @(negedge clk);
            seen = cmd_valid[0];
            n++;
        end
        chk("pending_before_reset", seen, 1);
        reset = 1'b1;
        #1;
        chk("reset_drops_valid", cmd_valid[0], 0);
        chk("reset_occ", occ0, 0);
        chk("reset_no_grant", wr_grant[0], 0);
        wr_req[0] = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        cmd_ready[0] = 1'b1;
        for (int u = 0; u < 2; u++) begin
            m_wr[u] = 0; m_rd[u] = 0; m_occ[u] = 0;
        end
        @(negedge clk);
        cmd(0, 1'b1, 1'b0, 1'b1, 0);
        chk("post_reset_addr", cmd_addr[0], 0);
        chk("scoreboard_drained", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
